johnson_bcd_framer: RTL and testbench

- Downstream consumer of a capture stage.
- Accepts one triplet of 5-bit Johnson-coded decimal digits (hundreds, tens, units) per handshake.
- Decodes the triplet, flags illegal codes, converts to binary 0..999 and serialises the result as a fixed byte frame on an 8-bit LED bus, one byte per advance strobe.
- Sits between a capture instance and the scan/LED output path, all on i_clk.

---
 rtl/ring_pkg.sv | 34 +++
 rtl/johnson_digit_decode.sv | 29 ++
 rtl/johnson_bcd_framer.sv | 148 ++++++++++++++
 tb/tb_johnson_bcd_framer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared constants for johnson_bcd_framer: Johnson digit codes, FSM encoding, frame geometry.
// Optional macro FRAME_SEQ_EN selects the 5-byte frame carrying a sequence byte.
package ring_pkg;

    localparam logic [4:0] JC_0 = 5'b00000;
    localparam logic [4:0] JC_1 = 5'b00001;
    localparam logic [4:0] JC_2 = 5'b00011;
    localparam logic [4:0] JC_3 = 5'b00111;
    localparam logic [4:0] JC_4 = 5'b01111;
    localparam logic [4:0] JC_5 = 5'b11111;
    localparam logic [4:0] JC_6 = 5'b11110;
    localparam logic [4:0] JC_7 = 5'b11100;
    localparam logic [4:0] JC_8 = 5'b11000;
    localparam logic [4:0] JC_9 = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEC,
        ST_CALC,
        ST_SEND
    } state_t;

    localparam int FRAME_LEN_BASE = 4;
    localparam int FRAME_LEN_SEQ  = 5;
`ifdef FRAME_SEQ_EN
    localparam int FRAME_LEN = FRAME_LEN_SEQ;
`else
    localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

    localparam int IDX_W = 3;
    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/johnson_digit_decode.sv
// Combinational decode of one 5-bit Johnson-coded decimal digit; illegal codes give 0 and err.
module johnson_digit_decode
    import ring_pkg::*;
(
    input  logic [4:0] code,
    output logic [3:0] digit,
    output logic       err
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        digit = 4'd0;
        err   = 1'b0;
        case (code)
            JC_0:    digit = 4'd0;
            JC_1:    digit = 4'd1;
            JC_2:    digit = 4'd2;
            JC_3:    digit = 4'd3;
            JC_4:    digit = 4'd4;
            JC_5:    digit = 4'd5;
            JC_6:    digit = 4'd6;
            JC_7:    digit = 4'd7;
            JC_8:    digit = 4'd8;
            JC_9:    digit = 4'd9;
            default: err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/johnson_bcd_framer.sv
// Johnson triplet -> binary 0..999 -> byte frame on the LED bus, one byte per advance.
// Macro FRAME_SEQ_EN inserts an 8-bit frame sequence byte before the checksum.
module johnson_bcd_framer
    import ring_pkg::*;
#(
    parameter logic [3:0]  pSYNC = 4'hA,
    parameter int unsigned pHOLD = 0
)(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [4:0] i_100,
    input  logic [4:0] i_010,
    input  logic [4:0] i_001,
    input  logic       i_adv,
    output logic [7:0] o_byte,
    output logic       o_busy,
    output logic [2:0] o_err
);

    localparam bit         HOLD_EN   = (pHOLD > 0);
    localparam logic [7:0] HOLD_LAST = (pHOLD > 0) ? 8'(pHOLD - 1) : 8'd0;
    localparam idx_t       LAST_IDX  = idx_t'(FRAME_LEN - 1);

    state_t     state;
    logic [4:0] c100_q, c010_q, c001_q;
    logic [3:0] d100, d010, d001;
    logic [2:0] err_dec;
    logic [3:0] d100_q, d010_q, d001_q;
    logic [2:0] err_dec_q;
    logic [9:0] bin_calc, bin_q, bin_src;
    logic [2:0] err_src;
    idx_t       idx, next_idx;
    logic [7:0] hold_cnt;
    logic [7:0] b0, b1, b2, chk, next_byte;
    logic       timeout, adv;
`ifdef FRAME_SEQ_EN
    logic [7:0] seq_q;
`endif

    johnson_digit_decode u_dec_100 (.code(c100_q), .digit(d100), .err(err_dec[2]));
    johnson_digit_decode u_dec_010 (.code(c010_q), .digit(d010), .err(err_dec[1]));
    johnson_digit_decode u_dec_001 (.code(c001_q), .digit(d001), .err(err_dec[0]));

    // In CALC the frame is built from the fresh decode; in SEND from the registered result.
    always_comb begin
        bin_calc  = 10'(d100_q) * 10'd100 + 10'(d010_q) * 10'd10 + 10'(d001_q);
        err_src   = (state == ST_CALC) ? err_dec_q : o_err;
        bin_src   = (state == ST_CALC) ? bin_calc  : bin_q;
        next_idx  = (state == ST_CALC) ? '0 : idx + 1'b1;
        b0        = {pSYNC, 1'b0, err_src};
        b1        = {6'b0, bin_src[9:8]};
        b2        = bin_src[7:0];
        chk       = b0 ^ b1 ^ b2;
`ifdef FRAME_SEQ_EN
        chk       = chk ^ seq_q;
`endif
        next_byte = 8'h00;
        case (next_idx)
            3'd0:    next_byte = b0;
            3'd1:    next_byte = b1;
            3'd2:    next_byte = b2;
`ifdef FRAME_SEQ_EN
            3'd3:    next_byte = seq_q;
            3'd4:    next_byte = chk;
`else
            3'd3:    next_byte = chk;
`endif
            default: next_byte = 8'h00;
        endcase
        timeout   = HOLD_EN && (hold_cnt == HOLD_LAST);
        adv       = i_adv || timeout;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            o_ready   <= 1'b1;
            o_busy    <= 1'b0;
            o_byte    <= 8'h00;
            o_err     <= 3'b000;
            c100_q    <= '0;
            c010_q    <= '0;
            c001_q    <= '0;
            d100_q    <= '0;
            d010_q    <= '0;
            d001_q    <= '0;
            err_dec_q <= '0;
            bin_q     <= '0;
            idx       <= '0;
            hold_cnt  <= '0;
`ifdef FRAME_SEQ_EN
            seq_q     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        c100_q  <= i_100;
                        c010_q  <= i_010;
                        c001_q  <= i_001;
                        o_ready <= 1'b0;
                        state   <= ST_DEC;
                    end
                end
                ST_DEC: begin
                    d100_q    <= d100;
                    d010_q    <= d010;
                    d001_q    <= d001;
                    err_dec_q <= err_dec;
                    state     <= ST_CALC;
                end
                ST_CALC: begin
                    bin_q    <= bin_calc;
                    o_err    <= err_dec_q;
                    idx      <= '0;
                    hold_cnt <= '0;
                    o_byte   <= next_byte;
                    o_busy   <= 1'b1;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (adv) begin
                        hold_cnt <= '0;
                        if (idx == LAST_IDX) begin
                            o_byte  <= 8'h00;
                            o_busy  <= 1'b0;
                            o_ready <= 1'b1;
                            state   <= ST_IDLE;
`ifdef FRAME_SEQ_EN
                            seq_q   <= seq_q + 8'd1;
`endif
                        end else begin
                            idx    <= next_idx;
                            o_byte <= next_byte;
                        end
                    end else if (HOLD_EN) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_johnson_bcd_framer.sv
// Directed bench: instance 0 manual advance (pHOLD=0), instance 1 auto advance (pHOLD=4).
module tb_johnson_bcd_framer;

    logic       clk;
    logic       rst_n;
    logic       valid [2];
    logic [4:0] c100  [2];
    logic [4:0] c010  [2];
    logic [4:0] c001  [2];
    logic       adv   [2];
    logic       ready [2];
    logic       busy  [2];
    logic [7:0] obyte [2];
    logic [2:0] oerr  [2];

    int         checks;
    int         errors;
    logic [7:0] exp_f   [5];
    int         exp_n;
    logic [7:0] exp_seq [2];
    logic [2:0] exp_err [2];

    johnson_bcd_framer #(.pSYNC(4'hA), .pHOLD(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid[0]), .o_ready(ready[0]),
        .i_100(c100[0]), .i_010(c010[0]), .i_001(c001[0]), .i_adv(adv[0]),
        .o_byte(obyte[0]), .o_busy(busy[0]), .o_err(oerr[0])
    );

    johnson_bcd_framer #(.pSYNC(4'hA), .pHOLD(4)) dut_h (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid[1]), .o_ready(ready[1]),
        .i_100(c100[1]), .i_010(c010[1]), .i_001(c001[1]), .i_adv(adv[1]),
        .o_byte(obyte[1]), .o_busy(busy[1]), .o_err(oerr[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected frame from the hand-computed 4-byte base frame; the sequence byte comes from a counter.
    task automatic set_frame(input int s, input logic [7:0] b0, b1, b2, ck);
        exp_f[0] = b0;
        exp_f[1] = b1;
        exp_f[2] = b2;
`ifdef FRAME_SEQ_EN
        exp_f[3] = exp_seq[s];
        exp_f[4] = ck ^ exp_seq[s];
        exp_n    = 5;
`else
        exp_f[3] = ck;
        exp_f[4] = 8'h00;
        exp_n    = 4;
`endif
    endtask

    task automatic check_idle(input int s, input string tag);
        check({tag, "_byte"},  32'(obyte[s]), 32'h00);
        check({tag, "_busy"},  32'(busy[s]),  32'd0);
        check({tag, "_ready"}, 32'(ready[s]), 32'd1);
        check({tag, "_err"},   32'(oerr[s]),  32'(exp_err[s]));
    endtask

    // Handshake at cycle T; returns at the negedge of T+3 (first SEND cycle).
    task automatic send_triplet(input int s, input logic [4:0] h, t, u, input logic [2:0] e);
        check("acc_ready", 32'(ready[s]), 32'd1);
        valid[s] = 1'b1;
        c100[s]  = h;
        c010[s]  = t;
        c001[s]  = u;
        @(negedge clk);
        valid[s] = 1'b0;
        check("dec_ready", 32'(ready[s]), 32'd0);
        check("dec_busy",  32'(busy[s]),  32'd0);
        @(negedge clk);
        check("calc_busy", 32'(busy[s]),  32'd0);
        @(negedge clk);
        exp_err[s] = e;
        check("send_busy",  32'(busy[s]),  32'd1);
        check("send_ready", 32'(ready[s]), 32'd0);
        check("send_err",   32'(oerr[s]),  32'(e));
    endtask

    task automatic read_frame_manual(input int s);
        for (int i = 0; i < exp_n; i++) begin
            check($sformatf("byte%0d", i), 32'(obyte[s]), 32'(exp_f[i]));
            adv[s] = 1'b1;
            @(negedge clk);
            adv[s] = 1'b0;
            if (i < exp_n - 1) begin
                @(negedge clk);
            end
        end
        check_idle(s, "end");
        exp_seq[s] = exp_seq[s] + 8'd1;
    endtask

    // pHOLD=4 frame: early advances the given byte after 2 cycles, coinc pulses i_adv on the timeout cycle.
    task automatic read_frame_hold(input int s, input int early, input int coinc);
        int len;
        for (int i = 0; i < exp_n; i++) begin
            len = (i == early) ? 2 : 4;
            for (int k = 0; k < len; k++) begin
                check($sformatf("hold_b%0d_c%0d", i, k), 32'(obyte[s]), 32'(exp_f[i]));
                check("hold_ready", 32'(ready[s]), 32'd0);
                adv[s]   = ((i == early) && (k == len - 1)) || ((i == coinc) && (k == 3));
                valid[s] = (i == 1) && (k == 0);
                c100[s]  = 5'b11111;
                @(negedge clk);
                adv[s]   = 1'b0;
                valid[s] = 1'b0;
            end
        end
        check_idle(s, "hold_end");
        @(negedge clk);
        check_idle(s, "hold_stay");
        exp_seq[s] = exp_seq[s] + 8'd1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        rst_n  = 1'b0;
        exp_n  = 4;
        for (int s = 0; s < 2; s++) begin
            valid[s]   = 1'b0;
            adv[s]     = 1'b0;
            c100[s]    = '0;
            c010[s]    = '0;
            c001[s]    = '0;
            exp_seq[s] = '0;
            exp_err[s] = '0;
        end
        repeat (2) @(negedge clk);
        check_idle(0, "rst0");
        check_idle(1, "rst1");
        rst_n = 1'b1;
        @(negedge clk);

        adv[0] = 1'b1;
        @(negedge clk);
        adv[0] = 1'b0;
        check_idle(0, "idle_adv");

        repeat (2) begin
            set_frame(0, 8'hA0, 8'h01, 8'h5B, 8'hFA);
            send_triplet(0, 5'b00111, 5'b01111, 5'b11100, 3'b000);
            read_frame_manual(0);
        end

        set_frame(0, 8'hA0, 8'h03, 8'hE7, 8'h44);
        send_triplet(0, 5'b10000, 5'b10000, 5'b10000, 3'b000);
        read_frame_manual(0);

        set_frame(0, 8'hA4, 8'h00, 8'h00, 8'hA4);
        send_triplet(0, 5'b10101, 5'b00000, 5'b00000, 3'b100);
        read_frame_manual(0);

        set_frame(1, 8'hA0, 8'h01, 8'h5B, 8'hFA);
        send_triplet(1, 5'b00111, 5'b01111, 5'b11100, 3'b000);
        read_frame_hold(1, -1, -1);

        set_frame(1, 8'hA0, 8'h03, 8'hE7, 8'h44);
        send_triplet(1, 5'b10000, 5'b10000, 5'b10000, 3'b000);
        read_frame_hold(1, 2, 0);

        // Reset lands while byte2 is on the bus, between clock edges.
        set_frame(0, 8'hA0, 8'h01, 8'h5B, 8'hFA);
        send_triplet(0, 5'b00111, 5'b01111, 5'b11100, 3'b000);
        repeat (2) begin
            adv[0] = 1'b1;
            @(negedge clk);
            adv[0] = 1'b0;
        end
        check("mid_byte2", 32'(obyte[0]), 32'h5B);
        #2;
        rst_n = 1'b0;
        #1;
        exp_err[0] = 3'b000;
        exp_err[1] = 3'b000;
        check_idle(0, "async_rst");
        exp_seq[0] = 8'h00;
        exp_seq[1] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        set_frame(0, 8'hA0, 8'h03, 8'hE7, 8'h44);
        send_triplet(0, 5'b10000, 5'b10000, 5'b10000, 3'b000);
        read_frame_manual(0);

`ifdef FRAME_SEQ_EN
        for (int n = 0; n < 256; n++) begin
            set_frame(0, 8'hA0, 8'h01, 8'h5B, 8'hFA);
            send_triplet(0, 5'b00111, 5'b01111, 5'b11100, 3'b000);
            read_frame_manual(0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
